// File: rtl/lsu_mem_access_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_access_if
//   Bundles the load/store unit's request side (from the datapath) and its
//   word-addressed valid/ready data-memory port.
//
//   master : the LSU itself (consumes the request, drives the memory port)
//   slave  : the environment (datapath + data memory)
//
//   Request side : req_valid, is_load[2:0], is_store[2:0], addr[31:0],
//                  store_data[31:0] -> busy, done, err, load_data[31:0]
//   Memory side  : mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0],
//                  mem_wmask[3:0]   <- mem_ready, mem_rdata[31:0]
// -----------------------------------------------------------------------------
interface lsu_mem_access_if;
  logic        req_valid;
  logic [2:0]  is_load;
  logic [2:0]  is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, is_load, is_store, addr, store_data, mem_ready, mem_rdata,
    output busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output req_valid, is_load, is_store, addr, store_data, mem_ready, mem_rdata,
    input  busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_mem_access.sv
// -----------------------------------------------------------------------------
// lsu_mem_access
//   Load/store unit between the ALU (effective address) and register
//   writeback. Takes one access per request (funct3 codes, 3'b111 = none),
//   performs a single word-addressed transaction on the data-memory port and
//   returns an extended load result with a one-cycle done pulse.
//
//   Store path : byte-lane replication of store_data plus byte write mask.
//   Load path  : lane extraction from the read word, sign/zero extension.
//
// Parameters
//   TIMEOUT : cycles mem_req may wait for mem_ready before abort (0 = never)
//
// Optional feature
//   MISALIGN_CHECK_EN : when defined, misaligned halfword/word accesses finish
//                       immediately with err=1 and never reach memory. When not
//                       defined, halfwords ignore addr[0] and words addr[1:0].
//
// Ports
//   clk    : clock, all state on the rising edge
//   rst    : synchronous active-high reset
//   io_lsu : lsu_mem_access_if.master (request side + memory port)
// -----------------------------------------------------------------------------
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_mem_access_if.master      io_lsu
);

  localparam logic [2:0]  F3_NONE    = 3'b111;
  localparam int unsigned TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [2:0]   r_funct3;
  logic [1:0]   r_off;
  logic         r_mem_we;
  logic [31:0]  r_mem_addr;
  logic [31:0]  r_mem_wdata;
  logic [3:0]   r_mem_wmask;
  logic         r_err;
  logic [31:0]  r_load_data;
  logic [TW-1:0] r_timer;

  logic         w_ld_set;
  logic         w_st_set;
  logic         w_ld_legal;
  logic         w_st_legal;
  logic [2:0]   w_f3;
  logic         w_misalign;
  logic         w_accept;
  logic         w_reject;
  logic         w_complete;
  logic         w_timeout;
  logic [31:0]  w_wdata;
  logic [3:0]   w_wmask;
  logic [1:0]   w_shift;
  logic [31:0]  w_lane;
  logic [31:0]  w_load_ext;

  // ---------------------------------------------------------------------------
  // Request decode. funct3[1:0] encodes access size for both loads and stores
  // (00 byte, 01 half, 10 word), so one field serves both paths.
  // ---------------------------------------------------------------------------
  assign w_ld_set   = (io_lsu.is_load  != F3_NONE);
  assign w_st_set   = (io_lsu.is_store != F3_NONE);
  assign w_ld_legal = io_lsu.is_load  inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_st_legal = io_lsu.is_store inside {3'b000, 3'b001, 3'b010};
  assign w_f3       = w_ld_set ? io_lsu.is_load : io_lsu.is_store;

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = ((w_f3[1:0] == 2'b01) && io_lsu.addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (io_lsu.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lane placement, computed from the live request and latched on accept.
  always_comb begin
    w_wdata = io_lsu.store_data;
    w_wmask = 4'b1111;
    case (io_lsu.is_store[1:0])
      2'b00: begin
        w_wdata = {4{io_lsu.store_data[7:0]}};
        w_wmask = 4'b0001 << io_lsu.addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{io_lsu.store_data[15:0]}};
        w_wmask = io_lsu.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension from the returned word.
  always_comb begin
    w_shift = 2'b00;
    case (r_funct3[1:0])
      2'b00:   w_shift = r_off;
      2'b01:   w_shift = {r_off[1], 1'b0};
      default: w_shift = 2'b00;
    endcase
    w_lane = io_lsu.mem_rdata >> {w_shift, 3'b000};
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'h0, w_lane[7:0]};
      3'b101:  w_load_ext = {16'h0, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs.
  // NOTE: every signal gets a default at the top of the block so that no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_reject       = 1'b0;
    w_complete     = 1'b0;
    w_timeout      = 1'b0;
    io_lsu.busy    = 1'b0;
    io_lsu.done    = 1'b0;
    io_lsu.err     = 1'b0;
    io_lsu.mem_req = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A request with neither code set is simply not an access.
        if (io_lsu.req_valid && (w_ld_set || w_st_set)) begin
          if ((w_ld_set && w_st_set) ||
              (w_ld_set && !w_ld_legal) ||
              (w_st_set && !w_st_legal) ||
              w_misalign) begin
            w_reject    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        io_lsu.busy    = 1'b1;
        io_lsu.mem_req = 1'b1;
        // Ready in the final allowed cycle still completes the access.
        if (io_lsu.mem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end else if ((TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        io_lsu.busy = 1'b1;
        io_lsu.done = 1'b1;
        io_lsu.err  = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wmask <= 4'b0000;
      r_err       <= 1'b0;
      r_load_data <= 32'h0;
      r_timer     <= '0;
    end else begin
      if (w_accept) begin
        r_funct3    <= w_f3;
        r_off       <= io_lsu.addr[1:0];
        r_mem_we    <= w_st_set;
        r_mem_addr  <= {io_lsu.addr[31:2], 2'b00};
        r_mem_wdata <= w_st_set ? w_wdata : 32'h0;
        r_mem_wmask <= w_st_set ? w_wmask : 4'b0000;
        r_err       <= 1'b0;
        r_timer     <= '0;
      end
      if (w_reject || w_timeout) begin
        r_err <= 1'b1;
      end
      // Stores and aborted accesses leave the previous load result in place.
      if (w_complete && !r_mem_we) begin
        r_load_data <= w_load_ext;
      end
      if ((r_state == S_ACCESS) && !io_lsu.mem_ready && (TIMEOUT != 0)) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  assign io_lsu.load_data = r_load_data;
  assign io_lsu.mem_we    = r_mem_we;
  assign io_lsu.mem_addr  = r_mem_addr;
  assign io_lsu.mem_wdata = r_mem_wdata;
  assign io_lsu.mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_lsu_mem_access.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_access
//   Scoreboarded bench for lsu_mem_access. A byte-array reference model
//   predicts each transaction's outcome at issue time; a memory responder
//   serves the port with a chosen number of wait cycles; a monitor compares
//   every done pulse against the queued expectation.
// -----------------------------------------------------------------------------
module tb_lsu_mem_access;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_access_if bus ();

  lsu_mem_access #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_lsu (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] ld;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          req_cycles;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          wait_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] mem   [16];
  logic [7:0]  ref_b [64];
  logic [31:0] ref_ld;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] = v;
    for (int i = 0; i < 4; i++) ref_b[idx*4 + i] = v[8*i +: 8];
  endtask

  // Waits for the DUT to go idle, throwing junk requests at it meanwhile
  // (requests while busy must be ignored).
  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 60) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.is_load    = 3'($urandom);
      bus.is_store   = 3'($urandom);
      bus.addr       = $urandom;
      bus.store_data = $urandom;
      @(negedge clk);
      k++;
    end
    bus.req_valid = 1'b0;
    if (k >= 60) check("busy_release_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Predicts the outcome from the byte-level model, then presents the request
  // for one cycle.
  task automatic issue(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] a,
                       input logic [31:0] d, input int w, input bit track);
    exp_t        e;
    bit          ld_set, st_set, legal, sgn;
    int          size, off, offs, n;
    logic [31:0] base, val, ones;
    logic [2:0]  f3;

    ld_set = (ld != 3'b111);
    st_set = (st != 3'b111);
    wait_idle();

    f3    = ld_set ? ld : st;
    size  = 1 << f3[1:0];
    sgn   = ld_set && (ld == 3'b000 || ld == 3'b001);
    legal = !(ld_set && st_set) &&
            (ld_set ? (ld inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                    : (st inside {3'b000, 3'b001, 3'b010}));
    if (size > 4) size = 1;
`ifdef MISALIGN_CHECK_EN
    if (legal && (a % size) != 0) legal = 1'b0;
`endif
    base    = a & ~32'(size - 1);
    off     = int'(base[1:0]);
    e.ld    = ref_ld;
    e.we    = st_set;
    e.maddr = a & 32'hFFFF_FFFC;
    e.wdata = (size == 1) ? {4{d[7:0]}} : (size == 2) ? {2{d[15:0]}} : d;
    e.wmask = 4'b0000;
    if (st_set)
      for (int i = 0; i < 4; i++) e.wmask[i] = (i >= off) && (i < off + size);

    if (!legal) begin
      e.err = 1'b1; e.req_cycles = 0; offs = 1;
    end else if (w >= int'(TO)) begin
      e.err = 1'b1; e.req_cycles = TO; offs = TO + 1;
    end else begin
      e.err = 1'b0; e.req_cycles = w + 1; offs = w + 2;
      if (st_set) begin
        for (int i = 0; i < size; i++) ref_b[int'(base[5:0]) + i] = d[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_b[int'(base[5:0]) + i]) << (8*i));
        ones = '1;
        if (sgn && val[8*size-1]) val = val | (ones << (8*size));
        ref_ld = val;
        e.ld   = val;
      end
    end

    bus.req_valid  = 1'b1;
    bus.is_load    = ld;
    bus.is_store   = st;
    bus.addr       = a;
    bus.store_data = d;
    n = cyc;
    if ((ld_set || st_set) && legal) wait_q.push_back(w);
    if ((ld_set || st_set) && track) begin
      e.done_cyc = n + offs;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin : monitor
    int   req_cnt;
    exp_t e;
    req_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.busy) req_cnt = 0;
      if (!rst) begin
        if (bus.mem_req) req_cnt++;
        if (bus.done) begin
          check("done_has_request", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("err", 32'(bus.err), 32'(e.err));
            check("load_data", bus.load_data, e.ld);
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("mem_req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          end
          req_cnt = 0;
        end
      end
    end
  end

  // Memory responder: holds mem_ready low for the queued number of cycles,
  // then completes, checking the request fields at the handshake.
  initial begin : responder
    int         cnt;
    bit         active;
    logic [3:0] idx;
    exp_t       e;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    active = 1'b0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !rst) begin
        if (!active) begin
          check("mem_req_expected", 32'(wait_q.size() != 0), 32'd1);
          active = 1'b1;
          cnt = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (cnt == 0) begin
          idx           = bus.mem_addr[5:2];
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_we ? $urandom : mem[idx];
          check("mem_has_txn", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("mem_we", 32'(bus.mem_we), 32'(e.we));
            check("mem_addr", bus.mem_addr, e.maddr);
            check("mem_wmask", 32'(bus.mem_wmask), 32'(e.wmask));
            if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
          end
          if (bus.mem_we)
            for (int i = 0; i < 4; i++)
              if (bus.mem_wmask[i]) mem[idx][8*i +: 8] = bus.mem_wdata[8*i +: 8];
          active = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [2:0]  lds [5];
    logic [2:0]  ld, st;
    logic [31:0] a, d;
    int          r, w;
    lds = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    bus.req_valid  = 1'b0;
    bus.is_load    = 3'b111;
    bus.is_store   = 3'b111;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    ref_ld = 32'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_load_data", bus.load_data, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(3'b111, 3'b000, 32'h8000_0003, 32'h1234_56AB, 0, 1'b1);
    wait_idle();
    check("sb_lane3_written", 32'(mem[0][31:24]), 32'h0000_00AB);
    poke(0, 32'h0000_8000);
    issue(3'b000, 3'b111, 32'h8000_0001, 32'h0, 0, 1'b1);
    wait_idle();
    check("lb_sign", bus.load_data, 32'hFFFF_FF80);
    issue(3'b100, 3'b111, 32'h8000_0001, 32'h0, 0, 1'b1);
    wait_idle();
    check("lbu_zero", bus.load_data, 32'h0000_0080);
    poke(0, 32'h8001_0000);
    issue(3'b001, 3'b111, 32'h8000_0002, 32'h0, 3, 1'b1);
    wait_idle();
    check("lh_sign", bus.load_data, 32'hFFFF_8001);
    issue(3'b010, 3'b111, 32'h8000_0004, 32'h0, 10, 1'b1);
    wait_idle();
    check("lw_timeout_hold", bus.load_data, 32'hFFFF_8001);
    issue(3'b010, 3'b111, 32'h8000_0008, 32'h0, TO - 1, 1'b1);
    issue(3'b111, 3'b010, 32'h8000_0012, $urandom, 0, 1'b1);
    issue(3'b011, 3'b111, 32'h8000_0000, 32'h0, 0, 1'b1);
    issue(3'b110, 3'b111, 32'h8000_0000, 32'h0, 0, 1'b1);
    issue(3'b111, 3'b100, 32'h8000_0000, 32'h0, 0, 1'b1);
    issue(3'b000, 3'b000, 32'h8000_0000, 32'h0, 0, 1'b1);
    issue(3'b111, 3'b111, 32'h8000_0000, 32'h0, 0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in the middle of an access: no done, next request normal.
    issue(3'b010, 3'b111, 32'h8000_0020, 32'h0, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_ld = 32'h0;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_load_data", bus.load_data, 32'h0);
    repeat (3) @(negedge clk);

    // Reset and request on the same edge: reset wins.
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.is_load   = 3'b010;
    bus.is_store  = 3'b111;
    bus.addr      = 32'h8000_0000;
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    check("rst_wins_busy", 32'(bus.busy), 32'd0);
    check("rst_wins_mem_req", 32'(bus.mem_req), 32'd0);
    repeat (2) @(negedge clk);
    issue(3'b010, 3'b111, 32'h8000_0000, 32'h0, 1, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 19);
      a  = 32'h8000_0000 | 32'($urandom_range(0, 63));
      d  = $urandom;
      ld = 3'b111;
      st = 3'b111;
      if (r < 8)       ld = lds[$urandom_range(0, 4)];
      else if (r < 15) st = 3'($urandom_range(0, 2));
      else if (r < 17) ld = (r == 15) ? 3'b011 : 3'b110;
      else if (r < 18) st = 3'($urandom_range(3, 6));
      else if (r < 19) begin
        ld = lds[$urandom_range(0, 4)];
        st = 3'($urandom_range(0, 2));
      end
      w = ($urandom_range(0, 5) == 0) ? int'(TO) + int'($urandom_range(0, 3))
                                      : int'($urandom_range(0, TO - 1));
      issue(ld, st, a, d, w, 1'b1);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
